banked_mem_responder: RTL and testbench
=======================================

Name: banked_mem_responder

Overview:
- Responder end of the cache-to-memory interface: four-bank, word-addressed main-memory model serving the cache controller's read/write requests.
- A request to a busy bank is stalled. Read data returns on a fixed two-cycle pipeline.
- Sits below the cache controller inside mem_system.
- Replaces the behavioural memory with a synthesizable, cycle-exact block that the controller's read/wait/store and writeback sequences are timed against.

Parameters:
- ADDR_W, 16, byte address width; word index is addr[ADDR_W-1:1]
- DATA_W, 16, word width
- BANK_BUSY, 4, cycles a bank stays occupied after accepting an access, counting the accept cycle; legal range 2..8

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  byte address of request; bank = addr[2:1]
- data_in  in  DATA_W  write data
- rd  in  1  read request, held by initiator while stall=1
- wr  in  1  write request, held by initiator while stall=1
- data_out  out  DATA_W  read data, valid only when rd_valid=1, else 0
- rd_valid  out  1  one-cycle pulse qualifying data_out
- stall  out  1  combinational: presented request not accepted this cycle
- busy  out  4  per-bank occupancy, bit i = bank i counter nonzero
- err  out  1  registered one-cycle pulse: illegal request seen

Behaviour:
- Reset, asynchronous on rst_n low:
  - All bank counters = 0; busy = 0.
  - Read pipeline valid bits = 0.
  - data_out = 0, rd_valid = 0, err = 0.
  - Array contents are not reset; they are undefined until written.
- Reset asserted mid-operation discards any in-flight read: no rd_valid is ever produced for it.
- Request legality:
  - Legal: exactly one of rd/wr high, and addr[0] = 0.
  - Illegal: rd&wr, or rd|wr with addr[0] = 1. Illegal requests are never accepted.
  - On the edge after an illegal request is presented, err = 1 for one cycle. stall = 0 for illegal requests.
- stall = legal & busy[addr[2:1]]. stall = 0 when rd = wr = 0.
- Accept on rising edge k when legal & ~busy[bank]. On accept:
  - The bank's counter loads BANK_BUSY-1.
  - Each counter decrements by 1 per cycle while nonzero; it saturates at 0.
  - Same-bank next accept is earliest at edge k+BANK_BUSY; other banks may accept at edge k+1.
- Write: array[addr[ADDR_W-1:1]] <= data_in at edge k. No response pulse.
- Read:
  - Array word is captured into stage A at edge k and moved to stage B at edge k+1.
  - data_out = stage B data and rd_valid = 1 during the cycle following edge k+1 (accept + 2), for exactly one cycle.
  - Back-to-back reads to different banks give back-to-back rd_valid pulses in order.
- Simultaneous events:
  - A counter reload on accept and a decrement in the same cycle cannot both occur for one bank, since accept requires counter = 0.
  - A write and a pending read of the same word cannot overlap: the read captured its data at its own accept edge.
- Pipeline occupancy: at most one read enters per cycle. No backpressure on data_out; the initiator must consume it in that cycle.
- All four banks share one array indexed by full word address. Banking affects only timing.

Decomposition:
- Package mem_resp_pkg holds:
  - bank field position (addr[2:1]);
  - BANK_BUSY default and counter width (3 bits);
  - the legality-check function.
- One natural sub-module, bank_busy_ctr, instantiated 4×: load / decrement / nonzero flag.
- Array and read pipeline stay in the top.

Test Plan:
- Reset then idle → busy=0, stall=0, rd_valid=0, data_out=0, err=0 for 10 cycles.
- Write 0xBEEF @0x1004, then after 4 cycles read @0x1004 → accepted without stall; rd_valid=1 with data_out=0xBEEF exactly 2 cycles after the read accept.
- Write @0x0000, then on the next cycle read @0x0008 (same bank 0) → stall=1 for 3 cycles and busy[0]=1; accepted on the 4th edge. Read @0x0002 (bank 1) on the cycle right after the write → no stall.
- Reads @0x0000, 0x0002, 0x0004, 0x0006 on consecutive cycles (preloaded 0x11, 0x22, 0x33, 0x44) → four consecutive rd_valid pulses carrying 0x11, 0x22, 0x33, 0x44.
- rd=wr=1 @0x0010, and separately rd @0x0011 → err pulse 1 cycle each, stall=0, no array change, no rd_valid.
- Read accepted, rst_n pulsed low on the next cycle → rd_valid never asserts; busy=0 immediately while rst_n is low.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared constants and the request legality check for the banked memory responder.
package mem_resp_pkg;

    localparam int BANK_LSB      = 1;
    localparam int BANK_MSB      = 2;
    localparam int NUM_BANKS     = 4;
    localparam int BANK_BUSY_DEF = 4;
    localparam int CNT_W         = 3;

    // Exactly one of rd/wr, and a word-aligned address.
    function automatic logic req_legal(input logic rd, input logic wr, input logic a0);
        return (rd ^ wr) & ~a0;
    endfunction

endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the memory responder (slave).
interface banked_mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic                 rd;
    logic                 wr;
    logic [DATA_W-1:0]    data_out;
    logic                 rd_valid;
    logic                 stall;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, rd_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, rd_valid, stall, busy, err
    );
endinterface

// File: rtl/bank_busy_ctr.sv
// Per-bank occupancy timer: loads on accept, counts down to zero, flags nonzero.
module bank_busy_ctr
    import mem_resp_pkg::*;
#(
    parameter int BANK_BUSY = BANK_BUSY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic busy_o
);
    // The accept cycle itself counts as one busy cycle, hence the minus one.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BANK_BUSY - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-addressed memory responder with bank-busy stalls and a fixed two-stage read pipeline.
module banked_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BANK_BUSY = BANK_BUSY_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    banked_mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 1);

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [NUM_BANKS-1:0] busy;
    logic [NUM_BANKS-1:0] load;
    logic [1:0]           bank;
    logic [ADDR_W-2:0]    word;
    logic                 legal, accept, illegal;

    logic              err_q, err_d;
    logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;

    assign legal   = req_legal(bus.rd, bus.wr, bus.addr[0]);
    assign illegal = (bus.rd | bus.wr) & ~legal;
    assign bank    = bus.addr[BANK_MSB:BANK_LSB];
    assign word    = bus.addr[ADDR_W-1:1];
    assign accept  = legal & ~busy[bank];

    genvar i;
    generate
        for (i = 0; i < NUM_BANKS; i++) begin : g_bank
            assign load[i] = accept & (bank == 2'(i));
            bank_busy_ctr #(.BANK_BUSY(BANK_BUSY)) u_ctr (
                .clk    (clk),
                .rst_n  (rst_n),
                .load_i (load[i]),
                .busy_o (busy[i])
            );
        end
    endgenerate

    // Array is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (accept & bus.wr) begin
            mem_q[word] <= bus.data_in;
        end
    end

    always_comb begin
        err_d    = illegal;
        a_vld_d  = accept & bus.rd;
        a_data_d = a_data_q;
        if (accept & bus.rd) begin
            a_data_d = mem_q[word];
        end
        b_vld_d  = a_vld_q;
        b_data_d = a_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            a_vld_q  <= 1'b0;
            a_data_q <= '0;
            b_vld_q  <= 1'b0;
            b_data_q <= '0;
        end else begin
            err_q    <= err_d;
            a_vld_q  <= a_vld_d;
            a_data_q <= a_data_d;
            b_vld_q  <= b_vld_d;
            b_data_q <= b_data_d;
        end
    end

    assign bus.stall    = legal & busy[bank];
    assign bus.busy     = busy;
    assign bus.err      = err_q;
    assign bus.rd_valid = b_vld_q;
    assign bus.data_out = b_vld_q ? b_data_q : '0;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Scoreboard bench for banked_mem_responder: directed requests, monitor checks read data and timing.
module tb_banked_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    banked_mem_responder_if bus ();

    banked_mem_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every rd_valid pulse must match the head of the scoreboard in data and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", {16'h0, bus.data_out}, {16'h0, e.data});
                    check("rd_cycle", cyc, e.due);
                end
            end else if (rst_n) begin
                check("data_out_idle_zero", {16'h0, bus.data_out}, 32'h0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd, input logic push,
                          output int nstall, output logic [3:0] busy_first);
        bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d;
        nstall = 0;
        @(negedge clk);
        busy_first = bus.busy;
        while (bus.stall === 1'b1 && nstall < 20) begin
            nstall++;
            @(negedge clk);
        end
        if (nstall >= 20) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        if (r && push) exp_q.push_back('{data: exp_rd, due: cyc + 1});
        bus.rd = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic illegal_req(input logic r, input logic w, input logic [15:0] a, input string name);
        bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = 16'hDEAD;
        @(negedge clk);
        check({name, "_stall"}, {31'h0, bus.stall}, 32'd0);
        check({name, "_err_before"}, {31'h0, bus.err}, 32'd0);
        @(posedge clk);
        #1;
        bus.rd = 1'b0; bus.wr = 1'b0;
        @(negedge clk);
        check({name, "_err_pulse"}, {31'h0, bus.err}, 32'd1);
        @(negedge clk);
        check({name, "_err_clear"}, {31'h0, bus.err}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [3:0] bf;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle", {bus.busy, bus.stall, bus.rd_valid, bus.err, bus.data_out},
                  32'h0);
        end
        @(posedge clk); #1;

        // Write then read back from bank 2 after it has gone idle.
        do_req(0, 1, 16'h1004, 16'hBEEF, 16'h0, 0, n, bf);
        idle(4);
        do_req(1, 0, 16'h1004, 16'h0, 16'hBEEF, 1, n, bf);
        check("beef_read_nostall", n, 0);
        idle(4);

        // Preload one word per bank, then read them back-to-back.
        do_req(0, 1, 16'h0000, 16'h0011, 16'h0, 0, n, bf);
        check("preload_b0_nostall", n, 0);
        do_req(0, 1, 16'h0002, 16'h0022, 16'h0, 0, n, bf);
        check("preload_b1_nostall", n, 0);
        do_req(0, 1, 16'h0004, 16'h0033, 16'h0, 0, n, bf);
        check("preload_b2_nostall", n, 0);
        do_req(0, 1, 16'h0006, 16'h0044, 16'h0, 0, n, bf);
        check("preload_b3_nostall", n, 0);
        idle(4);
        do_req(1, 0, 16'h0000, 16'h0, 16'h0011, 1, n, bf);
        check("b2b_rd0_nostall", n, 0);
        do_req(1, 0, 16'h0002, 16'h0, 16'h0022, 1, n, bf);
        check("b2b_rd1_nostall", n, 0);
        do_req(1, 0, 16'h0004, 16'h0, 16'h0033, 1, n, bf);
        check("b2b_rd2_nostall", n, 0);
        do_req(1, 0, 16'h0006, 16'h0, 16'h0044, 1, n, bf);
        check("b2b_rd3_nostall", n, 0);
        idle(4);

        // Same-bank read right after a write stalls for BANK_BUSY-1 cycles.
        do_req(0, 1, 16'h0008, 16'h5A5A, 16'h0, 0, n, bf);
        do_req(0, 1, 16'h0000, 16'h1234, 16'h0, 0, n, bf);
        check("wr0_after_wr8_stall", n, 3);
        do_req(1, 0, 16'h0008, 16'h0, 16'h5A5A, 1, n, bf);
        check("same_bank_stall_cycles", n, 3);
        check("same_bank_busy0", {31'h0, bf[0]}, 32'd1);
        idle(4);

        // Other bank right after a write is not stalled.
        do_req(0, 1, 16'h0000, 16'h7777, 16'h0, 0, n, bf);
        do_req(1, 0, 16'h0002, 16'h0, 16'h0022, 1, n, bf);
        check("other_bank_nostall", n, 0);
        idle(4);
        do_req(1, 0, 16'h0000, 16'h0, 16'h7777, 1, n, bf);
        idle(4);

        // Illegal requests: err pulse, no stall, no array change, no response.
        do_req(0, 1, 16'h0010, 16'hCAFE, 16'h0, 0, n, bf);
        idle(4);
        illegal_req(1, 1, 16'h0010, "rdwr");
        illegal_req(1, 0, 16'h0011, "misaligned");
        idle(4);
        do_req(1, 0, 16'h0010, 16'h0, 16'hCAFE, 1, n, bf);
        idle(6);

        // Reset right after a read accept discards it.
        do_req(1, 0, 16'h1004, 16'h0, 16'h0, 0, n, bf);
        check("pre_reset_busy2", {31'h0, bus.busy[2]}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_busy_immediate", {28'h0, bus.busy}, 32'h0);
        check("reset_rd_valid", {31'h0, bus.rd_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
